pwmgen: RTL and testbench
=========================

# pwmgen

PWM generator for the brushed DC motor controller. Sits directly downstream of the SPI register interface inside `system`. It consumes the duty, direction and enable values written over SPI and drives the H-bridge `pwm[1:0]` and `motorena` pins. It also enforces cycle-by-cycle current limiting and latches off after sustained overcurrent.

## Interface

Parameters:
- `PRESCALE`, default 4: clk cycles per PWM count; legal range ≥2.
- `BLANK`, default 2: PWM counts at the start of each period during which `currentlimit` is ignored.
- `FAULT_LIMIT`, default 8: consecutive chopped periods that latch FAULT; legal range 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `duty`  in  8  requested duty; 0 = off, 255 = 100 %.
- `dir`  in  1  requested direction; 0 drives `pwm[0]`, 1 drives `pwm[1]`.
- `enable`  in  1  requested run enable.
- `ld`  in  1  one-clk strobe from the SPI register file; captures `duty`/`dir`/`enable`.
- `currentlimit`  in  1  asynchronous comparator output, active high.
- `fault_clr`  in  1  one-clk strobe that clears a latched fault.
- `pwm`  out  2  H-bridge drive, registered.
- `motorena`  out  1  bridge enable, registered.
- `fault`  out  1  latched overcurrent fault, registered.
- `period_tick`  out  1  one-clk pulse on every period boundary.

## Operation

- **Prescaler**
  - Counts 0..PRESCALE-1, then wraps.
  - Each wrap advances the 8-bit period counter `cnt` through 0..254, then wraps to 0.
  - Both counters free-run in all states.
- **Period boundary:** the clk on which `cnt` wraps 254→0. `period_tick` = 1 for that clk.
- **Pending registers**
  - `ld` writes `duty`, `dir` and `enable` into pending registers.
  - At each boundary, active registers are loaded from pending per the state machine.
- **On-time:** `on = (cnt < act_duty) && !chop`. duty 255 is on for all 255 counts.
- **States:**
  - IDLE: pwm=00, motorena=0. At boundary, if pending enable=1 → RUN and load active duty/dir.
  - RUN: pwm[act_dir]=on, other bit 0, motorena=1. At boundary:
    - trip count reaches FAULT_LIMIT → FAULT;
    - else pending enable=0 → IDLE;
    - else pending dir ≠ act_dir → DEAD;
    - else reload active duty and stay in RUN.
  - DEAD: pwm=00, motorena=1, for exactly one period. At next boundary → RUN with pending dir/duty, or → IDLE if pending enable=0.
  - FAULT: pwm=00, motorena=0, fault=1. `fault_clr` → IDLE. On exit, pending enable is cleared, so a new `ld` with enable=1 is required to restart.
- **Current limit**
  - `currentlimit` passes through a 2-flop synchronizer to give `cl_s`.
  - In RUN, when on=1, `cl_s`=1 and `cnt ≥ BLANK`: set `chop`. This forces pwm low for the rest of the period.
  - `chop` clears at the boundary.
  - Trip counter: at the boundary, +1 if `chop` was set, else cleared to 0. Saturates at FAULT_LIMIT. Cleared on leaving FAULT.
- **Boundary conditions**
  - `ld` on a boundary clk: the boundary uses the old pending values; the new values take effect at the next boundary.
  - FAULT has priority over every other transition.
  - `fault_clr` outside FAULT is ignored.
  - `cl_s` in IDLE, DEAD or FAULT is ignored.
  - `reset` mid-period takes effect on the next clk edge: state IDLE, all counters, pending/active registers, chop and trip counter = 0.
- **Reset values:** pwm=00, motorena=0, fault=0, period_tick=0.

## Timing

- Period = 255 × PRESCALE clks (1020 clks at default).
- Outputs are registered: pwm changes 1 clk after the `cnt`/state condition.
- `currentlimit` rising → pwm low in 3 clks (2 sync + 1 output register).
- `ld` → new duty visible: at the next boundary + 1 clk. Maximum latency is one period + 1 clk.
- Direction reversal leaves both pwm bits low for at least one full period.
- Trip to FAULT occurs at the FAULT_LIMIT-th consecutive chopped boundary. motorena falls 1 clk later.

## Structure

- Shared package `bdc_pkg` holds:
  - the state encoding `pwm_state_t` (IDLE, RUN, DEAD, FAULT);
  - `PWM_CNT_MAX = 8'd254`;
  - the pwm bit indices for each direction.
- One sub-module, `pwmgen_sync`: 2-flop synchronizer reset to 0, used for `currentlimit`.

## Test plan

1. **Reset and enable:** reset, then `ld` duty=128, dir=0, enable=1 (PRESCALE=4) → from the next boundary, pwm[0] high for 512 clks per 1020-clk period; pwm[1]=0; motorena=1.
2. **Duty extremes:** duty=0 → pwm=00 for the whole period with motorena=1. duty=255 → pwm[0]=1 for the entire period.
3. **Direction reversal:** in RUN, `ld` dir=1 → pwm=00 for exactly one full period, then pwm[1] toggles at the same duty; pwm[0] never high in that window.
4. **Chop:**
   - pulse `currentlimit` at cnt=10 with duty=200 → pwm low 3 clks later, stays low until the boundary, resumes next period; trip count=1.
   - pulse at cnt=1 (blanking) → no chop.
5. **Fault latch:** hold `currentlimit` high for 8 periods → fault=1, motorena=0, pwm=00 after the 8th boundary. `fault_clr` → IDLE. Output stays off until a new `ld` with enable=1.
6. **Boundary corner:** `ld` on the exact `period_tick` clk → old duty used for that period, new duty applied one period later. Assert reset mid-period → all outputs 0 on the next clk.

Source files
------------

// File: rtl/bdc_pkg.sv
// Shared definitions for the brushed DC motor controller blocks.
package bdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_FAULT = 2'd3
  } pwm_state_t;

  localparam logic [7:0] PWM_CNT_MAX = 8'd254;

  // H-bridge leg driven for each direction
  localparam int unsigned PWM_BIT_FWD = 0;
  localparam int unsigned PWM_BIT_REV = 1;

endpackage

// File: rtl/pwmgen_if.sv
// Command bus from the SPI register file into the PWM generator.
interface pwmgen_if;
  logic [7:0] duty;
  logic       dir;
  logic       enable;
  logic       ld;

  modport master (output duty, dir, enable, ld);
  modport slave  (input  duty, dir, enable, ld);
endinterface

// File: rtl/pwmgen_sync.sv
// Two-flop synchronizer for an asynchronous level input.
module pwmgen_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) {q, meta} <= 2'b00;
    else       {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/pwmgen.sv
// H-bridge PWM generator with cycle-by-cycle current limiting and a
// latched overcurrent fault after repeated chopped periods.
module pwmgen
  import bdc_pkg::*;
#(
  parameter int PRESCALE    = 4,
  parameter int BLANK       = 2,
  parameter int FAULT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  pwmgen_if.slave    cmd,
  input  logic       currentlimit,
  input  logic       fault_clr,
  output logic [1:0] pwm,
  output logic       motorena,
  output logic       fault,
  output logic       period_tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [3:0]    TRIP_MAX  = 4'(FAULT_LIMIT);
  localparam logic [7:0]    BLANK_CNT = 8'(BLANK);

  pwm_state_t    state, state_nxt;
  logic [PW-1:0] presc;
  logic [7:0]    cnt, pend_duty, act_duty;
  logic          pend_dir, pend_en, act_dir;
  logic          chop, chop_now, chop_any, on_raw, cl_s, boundary;
  logic          load_act, leave_fault;
  logic [3:0]    trip, trip_nxt;
  logic [1:0]    drive;

  pwmgen_sync u_cl_sync (.clk(clk), .reset(reset), .d(currentlimit), .q(cl_s));

  assign boundary = (presc == PRE_MAX) && (cnt == PWM_CNT_MAX);
  assign on_raw   = (cnt < act_duty) && !chop;
  // Chop acts on the same clk the synchronized comparator is seen, so the
  // bridge drops one register after cl_s rather than two.
  assign chop_now = (state == ST_RUN) && on_raw && cl_s && (cnt >= BLANK_CNT);
  assign chop_any = chop | chop_now;
  assign trip_nxt = !chop_any          ? 4'd0 :
                    (trip == TRIP_MAX) ? trip : trip + 4'd1;

  always_comb begin
    state_nxt   = state;
    load_act    = 1'b0;
    leave_fault = 1'b0;
    drive       = 2'b00;
    case (state)
      ST_IDLE: if (boundary && pend_en) begin
        state_nxt = ST_RUN;
        load_act  = 1'b1;
      end
      ST_RUN: begin
        if (on_raw && !chop_now) begin
          if (act_dir) drive[PWM_BIT_REV] = 1'b1;
          else         drive[PWM_BIT_FWD] = 1'b1;
        end
        if (boundary) begin
          if (trip_nxt == TRIP_MAX)   state_nxt = ST_FAULT;
          else if (!pend_en)          state_nxt = ST_IDLE;
          else if (pend_dir != act_dir) state_nxt = ST_DEAD;
          else                        load_act  = 1'b1;
        end
      end
      ST_DEAD: if (boundary) begin
        if (pend_en) begin
          state_nxt = ST_RUN;
          load_act  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: if (fault_clr) begin
        state_nxt   = ST_IDLE;
        leave_fault = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      presc       <= '0;
      cnt         <= 8'd0;
      pend_duty   <= 8'd0;
      pend_dir    <= 1'b0;
      pend_en     <= 1'b0;
      act_duty    <= 8'd0;
      act_dir     <= 1'b0;
      chop        <= 1'b0;
      trip        <= 4'd0;
      pwm         <= 2'b00;
      motorena    <= 1'b0;
      fault       <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state <= state_nxt;
      if (presc == PRE_MAX) begin
        presc <= '0;
        cnt   <= (cnt == PWM_CNT_MAX) ? 8'd0 : cnt + 8'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if (cmd.ld) begin
        pend_duty <= cmd.duty;
        pend_dir  <= cmd.dir;
        pend_en   <= cmd.enable;
      end
      // A cleared fault must be re-armed by a fresh enable write
      if (leave_fault) pend_en <= 1'b0;
      if (load_act) begin
        act_duty <= pend_duty;
        act_dir  <= pend_dir;
      end
      if (boundary)      chop <= 1'b0;
      else if (chop_now) chop <= 1'b1;
      if (leave_fault)   trip <= 4'd0;
      else if (boundary) trip <= trip_nxt;
      pwm         <= drive;
      motorena    <= (state == ST_RUN) || (state == ST_DEAD);
      fault       <= (state == ST_FAULT);
      period_tick <= boundary;
    end
  end
endmodule

// File: tb/tb_pwmgen.sv
// Directed bench for pwmgen: per-period on-time counts, chop, fault latch.
module tb_pwmgen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       currentlimit = 1'b0;
  logic       fault_clr = 1'b0;
  logic [1:0] pwm;
  logic       motorena, fault, period_tick;

  pwmgen_if bus ();

  pwmgen #(.PRESCALE(4), .BLANK(2), .FAULT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .cmd(bus), .currentlimit(currentlimit),
    .fault_clr(fault_clr), .pwm(pwm), .motorena(motorena), .fault(fault),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] duty;
    logic       dir;
    logic       en;
    int         p0;
    int         p1;
    int         me;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   p0c, p1c, mec;
  logic pre_s, post_s;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_tick !== 1'b1 && n < 1100);
    check("tick_wait", {31'b0, period_tick}, 1);
  endtask

  // Starts on a period_tick clk (cycle 0 of a period); returns on the next one.
  task automatic run_period(input bit do_ld, input logic [7:0] d, input logic dr,
                            input logic en, input int pulse_k, input bit clr0);
    p0c = 0; p1c = 0; mec = 0; pre_s = 1'bx; post_s = 1'bx;
    for (int k = 0; k < 1020; k++) begin
      bus.ld = (k == 0) && do_ld;
      if (k == 0 && do_ld) begin
        bus.duty = d; bus.dir = dr; bus.enable = en;
      end
      currentlimit = (pulse_k > 0) && (k == pulse_k);
      fault_clr    = (k == 0) && clr0;
      @(negedge clk);
      p0c += int'(pwm[0]);
      p1c += int'(pwm[1]);
      mec += int'(motorena);
      if (k + 1 == pulse_k + 2) pre_s  = pwm[0];
      if (k + 1 == pulse_k + 3) post_s = pwm[0];
    end
    bus.ld = 1'b0; currentlimit = 1'b0; fault_clr = 1'b0;
    check("tick_align", {31'b0, period_tick}, 1);
    if (period_tick !== 1'b1) wait_tick();
  endtask

  vec_t vecs[10];

  initial begin
    vecs = '{
      '{8'd128, 1'b0, 1'b1,  512,   0, 1020},  // start from IDLE
      '{8'd0,   1'b0, 1'b1,    0,   0, 1020},  // duty 0: bridge enabled, no drive
      '{8'd255, 1'b0, 1'b1, 1020,   0, 1020},  // duty 255: on all period
      '{8'd64,  1'b1, 1'b1,    0,   0, 1020},  // reversal: dead period
      '{8'd64,  1'b1, 1'b1,    0, 256, 1020},  // then reverse leg
      '{8'd200, 1'b1, 1'b1,    0, 800, 1020},
      '{8'd10,  1'b1, 1'b0,    0,   0,    0},  // disable -> IDLE
      '{8'd10,  1'b1, 1'b1,    0,  40, 1020},  // IDLE -> RUN reverse, no dead
      '{8'd1,   1'b0, 1'b1,    0,   0, 1020},  // reversal again
      '{8'd1,   1'b0, 1'b1,    4,   0, 1020}
    };
    bus.duty = 8'd0; bus.dir = 1'b0; bus.enable = 1'b0; bus.ld = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_pwm", {30'b0, pwm}, 0);
    check("rst_motorena", {31'b0, motorena}, 0);
    check("rst_fault", {31'b0, fault}, 0);
    check("rst_tick", {31'b0, period_tick}, 0);
    reset = 1'b0;
    wait_tick();

    for (int i = 0; i < 10; i++) begin
      run_period(1'b1, vecs[i].duty, vecs[i].dir, vecs[i].en, 0, 1'b0);
      run_period(1'b0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
      check($sformatf("v%0d_pwm0", i), p0c, vecs[i].p0);
      check($sformatf("v%0d_pwm1", i), p1c, vecs[i].p1);
      check($sformatf("v%0d_motorena", i), mec, vecs[i].me);
    end

    // Chop at cnt=10, recovery, chop right at blanking edge, blanked pulse
    run_period(1'b1, 8'd200, 1'b0, 1'b1, 0, 1'b0);
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 40, 1'b0);
    check("chop10_pre", {31'b0, pre_s}, 1);
    check("chop10_post", {31'b0, post_s}, 0);
    check("chop10_count", p0c, 42);
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    check("chop_resume", p0c, 800);
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 8, 1'b0);
    check("chop2_post", {31'b0, post_s}, 0);
    check("chop2_count", p0c, 10);
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 4, 1'b1);
    check("blank_post", {31'b0, post_s}, 1);
    check("blank_count", p0c, 800);
    check("clr_ignored_me", mec, 1020);
    check("clr_ignored_fault", {31'b0, fault}, 0);

    // Sustained overcurrent: FAULT at the 8th chopped boundary
    currentlimit = 1'b1;
    repeat (7) wait_tick();
    check("trip7_fault", {31'b0, fault}, 0);
    check("trip7_motorena", {31'b0, motorena}, 1);
    wait_tick();
    check("trip8_me_lag", {31'b0, motorena}, 1);
    @(negedge clk);
    check("trip8_fault", {31'b0, fault}, 1);
    check("trip8_motorena", {31'b0, motorena}, 0);
    check("trip8_pwm", {30'b0, pwm}, 0);
    currentlimit = 1'b0;
    wait_tick();
    check("fault_held", {31'b0, fault}, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    @(negedge clk);
    check("clr_fault", {31'b0, fault}, 0);
    check("clr_motorena", {31'b0, motorena}, 0);
    wait_tick();
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    check("post_clr_idle_me", mec, 0);
    run_period(1'b1, 8'd128, 1'b0, 1'b1, 0, 1'b0);
    check("rearm_ld_period_me", mec, 0);
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    check("rearm_pwm0", p0c, 512);
    check("rearm_me", mec, 1020);

    // ld on the period_tick clk: old duty for this period, new one after
    run_period(1'b1, 8'd32, 1'b0, 1'b1, 0, 1'b0);
    check("ld_tick_old", p0c, 512);
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    check("ld_tick_new", p0c, 128);

    // Reset mid-period
    repeat (20) @(negedge clk);
    check("pre_reset_pwm0", {31'b0, pwm[0]}, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pwm", {30'b0, pwm}, 0);
    check("mid_rst_motorena", {31'b0, motorena}, 0);
    check("mid_rst_fault", {31'b0, fault}, 0);
    check("mid_rst_tick", {31'b0, period_tick}, 0);
    reset = 1'b0;
    wait_tick();
    run_period(1'b0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    check("post_rst_idle_me", mec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
